// File: rtl/baud_rate_generator_frac.sv
// baud_rate_generator_frac: fractional-divisor tx bit tick and oversampled rx tick
// generator sharing one fixed-point divisor, with rx timebase realignment.
module baud_rate_generator_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [DIV_W-1:0]    baud_div_i,
  input  logic [FRAC_W-1:0]   baud_frac_i,
  input  logic                rx_sync_i,
  output logic                tx_tick_o,
  output logic                rx_tick_o,
  output logic [OVS_LOG2-1:0] rx_phase_o,
  output logic                rx_sample_o,
  output logic                cfg_err_o
);
  localparam int D_W  = DIV_W + FRAC_W;
  localparam int RF_W = FRAC_W + OVS_LOG2;
  localparam int RI_W = DIV_W - OVS_LOG2;
  localparam int OVS  = 1 << OVS_LOG2;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [FRAC_W-1:0]   tx_acc_q, tx_acc_d;
  logic                tx_c_q, tx_c_d, tx_tick_q, tx_tick_d;
  logic [RI_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [RF_W-1:0]     rx_acc_q, rx_acc_d;
  logic                rx_c_q, rx_c_d, rx_tick_q, rx_tick_d, rx_sample_q, rx_sample_d;
  logic [OVS_LOG2-1:0] rx_phase_q, rx_phase_d, phase_inc;
  logic [D_W-1:0]      d_w;
  logic [RI_W-1:0]     rx_int;
  logic [RF_W-1:0]     rx_frac;
  logic [DIV_W:0]      tx_nxt;
  logic [RI_W:0]       rx_nxt;
  logic [FRAC_W:0]     tx_sum;
  logic [RF_W:0]       rx_sum;
  logic                tx_term, rx_term, cfg_bad;

  assign d_w       = {div_q, frac_q};
  assign rx_int    = d_w[D_W-1:RF_W];
  assign rx_frac   = d_w[RF_W-1:0];
  assign tx_nxt    = {1'b0, tx_cnt_q} + {{DIV_W{1'b0}}, 1'b1};
  assign rx_nxt    = {1'b0, rx_cnt_q} + {{RI_W{1'b0}}, 1'b1};
  // terminal count when cnt+1 == I+c, compared one bit wider so I+c never wraps
  assign tx_term   = tx_nxt == {1'b0, div_q} + {{DIV_W{1'b0}}, tx_c_q};
  assign rx_term   = rx_nxt == {1'b0, rx_int} + {{RI_W{1'b0}}, rx_c_q};
  assign tx_sum    = {1'b0, tx_acc_q} + {1'b0, frac_q};
  assign rx_sum    = {1'b0, rx_acc_q} + {1'b0, rx_frac};
  assign phase_inc = rx_phase_q + OVS_LOG2'(1);
  assign cfg_bad   = baud_div_i < DIV_W'(OVS);

  always_comb begin
    div_d       = div_q;
    frac_d      = frac_q;
    cfg_err_d   = cfg_err_q;
    tx_cnt_d    = tx_cnt_q;
    tx_acc_d    = tx_acc_q;
    tx_c_d      = tx_c_q;
    rx_cnt_d    = rx_cnt_q;
    rx_acc_d    = rx_acc_q;
    rx_c_d      = rx_c_q;
    rx_phase_d  = rx_phase_q;
    tx_tick_d   = 1'b0;
    rx_tick_d   = 1'b0;
    rx_sample_d = 1'b0;
    if (load_i) begin
      div_d      = baud_div_i;
      frac_d     = baud_frac_i;
      cfg_err_d  = cfg_bad;
      tx_cnt_d   = '0;
      tx_acc_d   = '0;
      tx_c_d     = 1'b0;
      rx_cnt_d   = '0;
      rx_acc_d   = '0;
      rx_c_d     = 1'b0;
      rx_phase_d = '0;
    end else if (!cfg_err_q) begin
      if (en_i) begin
        tx_cnt_d           = tx_term ? '0 : tx_nxt[DIV_W-1:0];
        {tx_c_d, tx_acc_d} = tx_term ? tx_sum : {tx_c_q, tx_acc_q};
        tx_tick_d          = tx_term;
      end
      if (rx_sync_i) begin
        rx_cnt_d   = '0;
        rx_acc_d   = '0;
        rx_c_d     = 1'b0;
        rx_phase_d = '0;
      end else if (en_i) begin
        rx_cnt_d           = rx_term ? '0 : rx_nxt[RI_W-1:0];
        {rx_c_d, rx_acc_d} = rx_term ? rx_sum : {rx_c_q, rx_acc_q};
        rx_phase_d         = rx_term ? phase_inc : rx_phase_q;
        rx_tick_d          = rx_term;
        rx_sample_d        = rx_term && (phase_inc == OVS_LOG2'(OVS / 2));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q       <= baud_div_i;
      frac_q      <= baud_frac_i;
      cfg_err_q   <= cfg_bad;
      tx_cnt_q    <= '0;
      tx_acc_q    <= '0;
      tx_c_q      <= 1'b0;
      rx_cnt_q    <= '0;
      rx_acc_q    <= '0;
      rx_c_q      <= 1'b0;
      rx_phase_q  <= '0;
      tx_tick_q   <= 1'b0;
      rx_tick_q   <= 1'b0;
      rx_sample_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      frac_q      <= frac_d;
      cfg_err_q   <= cfg_err_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_acc_q    <= tx_acc_d;
      tx_c_q      <= tx_c_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_acc_q    <= rx_acc_d;
      rx_c_q      <= rx_c_d;
      rx_phase_q  <= rx_phase_d;
      tx_tick_q   <= tx_tick_d;
      rx_tick_q   <= rx_tick_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  assign tx_tick_o   = tx_tick_q;
  assign rx_tick_o   = rx_tick_q;
  assign rx_phase_o  = rx_phase_q;
  assign rx_sample_o = rx_sample_q;
  assign cfg_err_o   = cfg_err_q;
endmodule

// File: tb/tb_baud_rate_generator_frac.sv
// tb_baud_rate_generator_frac: scenario tasks checked against a closed-form tick-time model
// (k-th tick lands on enabled edge I + floor((k-1)*D / 2^W) after each restart).
module tb_baud_rate_generator_frac;
  localparam int FRAC_W = 4;
  localparam int OVS_LOG2 = 4;
  localparam int OVS = 16;

  logic clk = 1'b0, rst_i = 1'b0, en_i = 1'b0, load_i = 1'b0, rx_sync_i = 1'b0;
  logic [15:0] baud_div_i = '0;
  logic [3:0] baud_frac_i = '0;
  logic tx_tick_o, rx_tick_o, rx_sample_o, cfg_err_o;
  logic [3:0] rx_phase_o;
  int errors = 0, checks = 0;
  longint m_d = 0, m_i = 0, tn = 0, tk = 1, rn = 0, rk = 1;
  int ph = 0;
  bit m_err = 0;
  logic exp_tx = 0, exp_rx = 0, exp_smp = 0, exp_err = 0;
  logic [3:0] exp_ph = '0;

  baud_rate_generator_frac #(.DIV_W(16), .FRAC_W(FRAC_W), .OVS_LOG2(OVS_LOG2)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .load_i(load_i), .baud_div_i(baud_div_i),
    .baud_frac_i(baud_frac_i), .rx_sync_i(rx_sync_i), .tx_tick_o(tx_tick_o),
    .rx_tick_o(rx_tick_o), .rx_phase_o(rx_phase_o), .rx_sample_o(rx_sample_o),
    .cfg_err_o(cfg_err_o));

  always #5 clk = ~clk;

  function automatic longint tx_t(longint k);
    return m_i + (((k - 1) * m_d) >> FRAC_W);
  endfunction

  function automatic longint rx_t(longint k);
    return (m_d >> (FRAC_W + OVS_LOG2)) + (((k - 1) * m_d) >> (FRAC_W + OVS_LOG2));
  endfunction

  // advance the reference model for the coming edge, then clock and settle
  task automatic tick();
    exp_tx = 0; exp_rx = 0; exp_smp = 0;
    if (rst_i || load_i) begin
      m_i = longint'(baud_div_i);
      m_d = m_i * 16 + longint'(baud_frac_i);
      m_err = baud_div_i < 16;
      tn = 0; tk = 1; rn = 0; rk = 1; ph = 0;
    end else if (!m_err) begin
      if (en_i) begin
        tn++;
        if (tn == tx_t(tk)) begin exp_tx = 1; tk++; end
      end
      if (rx_sync_i) begin
        rn = 0; rk = 1; ph = 0;
      end else if (en_i) begin
        rn++;
        if (rn == rx_t(rk)) begin
          exp_rx = 1; rk++; ph = (ph + 1) % OVS; exp_smp = (ph == OVS / 2);
        end
      end
    end
    exp_err = m_err;
    exp_ph = 4'(ph);
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int div, input int frac);
    load_i = 1; baud_div_i = 16'(div); baud_frac_i = 4'(frac);
    tick();
    load_i = 0;
  endtask

  task automatic test_reset();
    en_i = 0; rst_i = 1; baud_div_i = 16; baud_frac_i = 0;
    tick();
    checks++;
    if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== 8'b0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, 8'b0);
    end
    baud_div_i = 5;
    tick();
    rst_i = 0; en_i = 1;
    checks++;
    if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== 8'b0000_0001) begin
      errors++; $display("FAIL reset_cfg_err: got %b expected %b", {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, 8'b1);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL reset_err_hold c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
    end
  endtask

  task automatic test_exact();
    int ntx = 0, nrx = 0, nsm = 0;
    en_i = 1;
    do_load(16, 0);
    for (int c = 1; c <= 320; c++) begin
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL exact c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      ntx += int'(tx_tick_o); nrx += int'(rx_tick_o);
      if (rx_sample_o && rx_phase_o == 4'd8) nsm++;
    end
    checks++;
    if (ntx != 20 || nrx != 320 || nsm != 20) begin
      errors++; $display("FAIL exact_counts: got tx=%0d rx=%0d smp=%0d expected 20 320 20", ntx, nrx, nsm);
    end
  endtask

  task automatic test_frac();
    int txq[$], rxq[$];
    int n869 = 0, n55 = 0, bad = 0;
    en_i = 1;
    do_load(868, 1);
    for (int c = 1; c <= 15000 && txq.size() < 17; c++) begin
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL frac c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      if (tx_tick_o) txq.push_back(c);
      if (rx_tick_o && rxq.size() < 257) rxq.push_back(c);
    end
    checks++;
    if (txq.size() < 17 || rxq.size() < 257) begin
      errors++; $display("FAIL frac_timeout: got tx=%0d rx=%0d ticks expected 17 257", txq.size(), rxq.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        if (txq[j+1] - txq[j] == 869) n869++;
        else if (txq[j+1] - txq[j] != 868) bad++;
      end
      for (int j = 0; j < 256; j++) begin
        if (rxq[j+1] - rxq[j] == 55) n55++;
        else if (rxq[j+1] - rxq[j] != 54) bad++;
      end
      if (n869 != 1 || bad != 0) begin
        errors++; $display("FAIL frac_tx_periods: got n869=%0d bad=%0d expected 1 0", n869, bad);
      end
      checks++;
      if (n55 != 65) begin
        errors++; $display("FAIL frac_rx_periods: got n55=%0d expected 65", n55);
      end
      checks++;
      if (txq[16] - txq[0] != 13889 || rxq[256] - rxq[0] != 13889) begin
        errors++; $display("FAIL frac_span: got tx=%0d rx=%0d expected 13889", txq[16] - txq[0], rxq[256] - rxq[0]);
      end
    end
  endtask

  task automatic test_sync();
    int first_rx = -1, ph_at = -1, tx1 = -1, tx2 = -1;
    en_i = 1;
    do_load(160, 0);
    for (int c = 1; c <= 330; c++) begin
      rx_sync_i = (c == 38);
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL sync c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      if (c > 38 && rx_tick_o && first_rx < 0) begin first_rx = c - 38; ph_at = int'(rx_phase_o); end
      if (tx_tick_o) begin if (tx1 < 0) tx1 = c; else if (tx2 < 0) tx2 = c; end
    end
    rx_sync_i = 0;
    checks++;
    if (first_rx != 10 || ph_at != 1) begin
      errors++; $display("FAIL sync_realign: got delay=%0d phase=%0d expected 10 1", first_rx, ph_at);
    end
    checks++;
    if (tx1 != 160 || tx2 != 320) begin
      errors++; $display("FAIL sync_tx_cadence: got %0d %0d expected 160 320", tx1, tx2);
    end
  endtask

  task automatic test_enable_gap();
    int tx1 = -1, gap_ticks = 0;
    en_i = 1;
    do_load(160, 0);
    for (int c = 1; c <= 200 && tx1 < 0; c++) begin
      en_i = !(c >= 51 && c <= 57);
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL gap c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      if (!en_i) gap_ticks += int'(tx_tick_o) + int'(rx_tick_o);
      if (tx_tick_o) tx1 = c;
    end
    en_i = 1;
    checks++;
    if (tx1 != 167 || gap_ticks != 0) begin
      errors++; $display("FAIL gap_extend: got tx=%0d gap_ticks=%0d expected 167 0", tx1, gap_ticks);
    end
  endtask

  task automatic test_cfg();
    int nt = 0, tx1 = -1, tx2 = -1;
    en_i = 1;
    do_load(15, 3);
    for (int c = 1; c <= 100; c++) begin
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL cfg_bad c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      nt += int'(tx_tick_o) + int'(rx_tick_o);
    end
    checks++;
    if (cfg_err_o !== 1'b1 || nt != 0) begin
      errors++; $display("FAIL cfg_err_hold: got err=%b ticks=%0d expected 1 0", cfg_err_o, nt);
    end
    do_load(32, 0);
    for (int c = 1; c <= 70; c++) begin
      if (c == 10) baud_div_i = 100;
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL cfg_good c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      if (tx_tick_o) begin if (tx1 < 0) tx1 = c; else if (tx2 < 0) tx2 = c; end
    end
    checks++;
    if (cfg_err_o !== 1'b0 || tx1 != 32 || tx2 != 64) begin
      errors++; $display("FAIL cfg_late: got err=%b tx=%0d,%0d expected 0 32,64", cfg_err_o, tx1, tx2);
    end
  endtask

  task automatic test_reset_mid();
    int tx1 = -1;
    en_i = 1;
    do_load(32, 0);
    for (int c = 1; c <= 31; c++) tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    checks++;
    if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== 8'b0) begin
      errors++; $display("FAIL reset_mid: got %b expected %b", {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, 8'b0);
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL reset_restart c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
      if (tx_tick_o && tx1 < 0) tx1 = c;
    end
    checks++;
    if (tx1 != 32) begin
      errors++; $display("FAIL reset_first_tick: got %0d expected 32", tx1);
    end
  endtask

  task automatic test_random();
    do_load(40, 7);
    for (int c = 1; c <= 4000; c++) begin
      load_i = ($urandom_range(0, 299) == 0);
      if (load_i || $urandom_range(0, 99) == 0) begin
        baud_div_i = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(16, 200));
        baud_frac_i = 4'($urandom);
      end
      en_i = ($urandom_range(0, 9) != 0);
      rx_sync_i = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if ({tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o} !== {exp_tx, exp_rx, exp_smp, exp_ph, exp_err}) begin
        errors++; $display("FAIL random c=%0d: got %b expected %b", c, {tx_tick_o, rx_tick_o, rx_sample_o, rx_phase_o, cfg_err_o}, {exp_tx, exp_rx, exp_smp, exp_ph, exp_err});
      end
    end
    load_i = 0; rx_sync_i = 0; en_i = 1;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_frac();
    test_sync();
    test_enable_gap();
    test_cfg();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/baud_rate_generator_frac.md
# baud_rate_generator_frac

Parametrised fractional baud tick generator for the UART subsystem. It produces a bit-rate tick for the transmitter and an oversampled tick for the receiver, plus receiver phase/sample-point outputs. Both ticks are derived from one fixed-point divisor, so fractional bit periods are accurate on average with at most one cycle of jitter. The receiver timebase can be realigned on a start-bit edge.

## Interface
- DIV_W, 16: integer divisor width; clocks per bit, integer part.
- FRAC_W, 4: fractional divisor width, in 1/2^FRAC_W clock units.
- OVS_LOG2, 4: log2 of the rx oversampling factor OVS; legal range 1 ≤ OVS_LOG2 < DIV_W.
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  count enable.
- load_i  in  1  latch a new divisor and restart both generators.
- baud_div_i  in  DIV_W  integer clocks per bit.
- baud_frac_i  in  FRAC_W  fractional clocks per bit.
- rx_sync_i  in  1  realign the rx timebase, for example on a start-bit edge.
- tx_tick_o  out  1  one-cycle pulse per bit period.
- rx_tick_o  out  1  one-cycle pulse, OVS per bit period.
- rx_phase_o  out  OVS_LOG2  count of rx ticks mod OVS.
- rx_sample_o  out  1  pulse with the rx_tick_o on which rx_phase_o becomes OVS/2.
- cfg_err_o  out  1  latched divisor is illegal.

## Operation
- Divisor D = {div, frac}, taken from shadow registers, in 1/2^FRAC_W clock units.
- tx generator:
  - Integer part I_t = div; fraction F_t = frac (FRAC_W bits).
- rx generator:
  - Period D/OVS.
  - Integer part I_r = D >> (FRAC_W+OVS_LOG2), width DIV_W-OVS_LOG2.
  - Fraction F_r = D[FRAC_W+OVS_LOG2-1:0].
- Each generator has a counter cnt, a fraction accumulator acc (mod 2^width of F) and a carry flag c. Its current period is P = I + c.
- Per enabled edge:
  - If cnt == P-1: cnt←0, tick←1, {c,acc}←acc+F.
  - Otherwise: cnt←cnt+1, tick←0.
- rx_phase_o increments on every rx tick and wraps from OVS-1 to 0.
- rx_sample_o←1 on the edge where the new rx_phase_o equals OVS/2.
- Priority: rst_i > load_i > rx_sync_i > en_i.
- rst_i and load_i:
  - Shadow←{baud_div_i, baud_frac_i}.
  - Clear all cnt, acc, c and rx_phase_o.
  - All pulses←0.
  - cfg_err_o←(baud_div_i < OVS).
- rx_sync_i: clear the rx cnt, acc, c and rx_phase_o, and drive rx ticks/sample to 0. The tx generator continues counting if en_i is high.
- en_i low: all state holds; tick outputs are 0.
- baud_div_i and baud_frac_i are ignored except on rst_i or load_i, so changes mid-frame have no effect until load_i.
- cfg_err_o high: both generators are held cleared and no pulses are emitted until a legal load.

## Timing
- Reset values:
  - tx_tick_o = 0, rx_tick_o = 0, rx_sample_o = 0, rx_phase_o = 0.
  - cfg_err_o reflects the inputs sampled at reset.
- All outputs are registered; there is no combinational path from inputs to outputs.
- First pulse:
  - Count enabled edges starting after the reset, load or sync edge.
  - The first tick rises on the I-th enabled edge.
  - The first period always uses c = 0.
- Period rules:
  - Consecutive ticks are I or I+1 cycles apart, with en_i high throughout.
  - I = 1 with F = 0 holds the tick continuously high.
- Long-run tick rates:
  - Over 2^FRAC_W tx periods, exactly D clocks elapse.
  - Over 2^(FRAC_W+OVS_LOG2) rx periods, exactly D clocks elapse.
- rx_sync_i asserted in the same cycle as an rx terminal count: the sync wins and no tick is emitted.
- load_i and rx_sync_i asserted together: the load wins.

## Test plan
- Exact divisor: div=16, frac=0 → tx_tick_o every 16 cycles; rx_tick_o high continuously; rx_sample_o on every 16th rx tick with phase 8.
- Fractional divisor: div=868, frac=1 (100 MHz/115200) → check each of the following.
  - Tx periods are 868 with one 869 per 16 ticks.
  - Rx periods are 54/55 with sixty-five 55s per 256 ticks.
  - 16 tx ticks and 256 rx ticks both span exactly 13889 cycles.
- Realignment: rx_sync_i mid-period with div=160, frac=0 → next rx_tick_o arrives exactly 10 cycles after the sync edge; rx_phase_o restarts at 1; tx cadence is undisturbed.
- Enable gating: drop en_i for 7 cycles mid-period → no ticks during the gap; the remaining count resumes; total period is extended by exactly 7.
- Illegal and late config:
  - load_i with div=15 → cfg_err_o=1 and no ticks.
  - load_i with div=32 → cfg_err_o=0; first tx tick after 32 enabled cycles.
  - Changing baud_div_i without load_i → no effect.
- Reset mid-operation: rst_i asserted one cycle before a tx terminal count → no tick; all outputs are 0 on the next cycle; the counting restart matches the first-pulse rule.
